// File: rtl/timer_pkg.sv
// Package: timer_pkg
// Shared types and constants for the MM:SS countdown timer.
//   state_t   - FSM state encoding {IDLE, RUN, PAUSE, DONE}
//   MIN_W     - width of the minutes field (holds up to 99)
//   SEC_W     - width of the seconds field (holds up to 59)
//   SEC_WRAP  - default seconds value restored on a minute borrow
//   SEC_MAX   - largest legal seconds value accepted on load
package timer_pkg;

    localparam int MIN_W    = 7;
    localparam int SEC_W    = 6;
    localparam int SEC_WRAP = 59;
    localparam int SEC_MAX  = 59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tick_edge_detect.sv
// Module: tick_edge_detect
// Turns the 1 Hz square wave (a data signal, not a clock) into a one-clk-wide
// pulse on each rising edge, in the clk domain.
// Optional feature macro: TICK_SYNC_EN
//   defined   - tick_in goes through a 2-flop synchronizer, then the edge
//               register; the pulse is seen at the 3rd clk edge after the rise.
//   undefined - a single edge register; the pulse is combinational from
//               tick_in and is seen at the 1st clk edge after the rise. Only
//               legal when tick_in is generated in the clk domain.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-high reset (clears all sampling flops)
//   tick_in   in  1 Hz square wave
//   tick_edge out one-clk-wide rising-edge pulse
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic tick_edge
);

`ifdef TICK_SYNC_EN
    logic sync1_reg;
    logic sync2_reg;
    logic tick_q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            tick_q_reg <= 1'b0;
        end else begin
            sync1_reg  <= tick_in;
            sync2_reg  <= sync1_reg;
            tick_q_reg <= sync2_reg;
        end
    end

    assign tick_edge = sync2_reg & ~tick_q_reg;
`else
    logic tick_q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q_reg <= 1'b0;
        end else begin
            tick_q_reg <= tick_in;
        end
    end

    // Because the flop resets to 0, a tick_in held high through reset
    // release produces exactly one edge.
    assign tick_edge = tick_in & ~tick_q_reg;
`endif

endmodule

// File: rtl/countdown_timer.sv
// Module: countdown_timer
// MM:SS countdown driven by rising edges of a 1 Hz square wave sampled in the
// clk domain. Supports load, start, pause, resume and an alarm state.
// Optional feature macro: TICK_SYNC_EN (see tick_edge_detect).
// Parameters:
//   MAX_MIN   saturation limit for loaded minutes
//   SEC_WRAP  seconds value restored when a minute borrow occurs
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   tick_in  in   1 Hz square wave
//   load     in   load min_in/sec_in (saturated), return to IDLE
//   min_in   in   minutes to load
//   sec_in   in   seconds to load
//   start    in   start / resume / acknowledge alarm
//   pause    in   pause while running
//   min_out  out  current minutes
//   sec_out  out  current seconds
//   running  out  high in RUN
//   alarm    out  high in DONE
//   done     out  one-cycle pulse when the count reaches 00:00
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MAX_MIN  = 99,
    parameter int SEC_WRAP = timer_pkg::SEC_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             load,
    input  logic [MIN_W-1:0] min_in,
    input  logic [SEC_W-1:0] sec_in,
    input  logic             start,
    input  logic             pause,
    output logic [MIN_W-1:0] min_out,
    output logic [SEC_W-1:0] sec_out,
    output logic             running,
    output logic             alarm,
    output logic             done
);

    localparam logic [MIN_W-1:0] MAX_MIN_V  = MIN_W'(MAX_MIN);
    localparam logic [SEC_W-1:0] SEC_MAX_V  = SEC_W'(SEC_MAX);
    localparam logic [SEC_W-1:0] SEC_WRAP_V = SEC_W'(SEC_WRAP);

    logic tick_edge;

    state_t           state_reg, state_next;
    logic [MIN_W-1:0] min_reg,   min_next;
    logic [SEC_W-1:0] sec_reg,   sec_next;
    logic             done_reg,  done_next;
    logic             running_reg;
    logic             alarm_reg;

    logic [MIN_W-1:0] min_sat;
    logic [SEC_W-1:0] sec_sat;
    logic             count_zero;

    tick_edge_detect u_tick_edge_detect (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .tick_edge (tick_edge)
    );

    assign min_sat    = (min_in > MAX_MIN_V) ? MAX_MIN_V : min_in;
    assign sec_sat    = (sec_in > SEC_MAX_V) ? SEC_MAX_V : sec_in;
    assign count_zero = (min_reg == '0) && (sec_reg == '0);

    // Next-state and counter logic. Priority: load > start/pause > tick_edge.
    always_comb begin
        state_next = state_reg;
        min_next   = min_reg;
        sec_next   = sec_reg;
        done_next  = 1'b0;

        if (load) begin
            min_next   = min_sat;
            sec_next   = sec_sat;
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !count_zero) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_next = PAUSE;
                    end else if (tick_edge) begin
                        if (sec_reg != '0) begin
                            sec_next = sec_reg - 1'b1;
                        end else if (min_reg != '0) begin
                            min_next = min_reg - 1'b1;
                            sec_next = SEC_WRAP_V;
                        end
                        // done fires in the cycle the displayed count turns 00:00
                        if ((min_next == '0) && (sec_next == '0)) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            min_reg     <= '0;
            sec_reg     <= '0;
            done_reg    <= 1'b0;
            running_reg <= 1'b0;
            alarm_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            min_reg     <= min_next;
            sec_reg     <= sec_next;
            done_reg    <= done_next;
            // Status flags are registered from the next state so they line up
            // with state_reg without a decode after the flops.
            running_reg <= (state_next == RUN);
            alarm_reg   <= (state_next == DONE);
        end
    end

    assign min_out = min_reg;
    assign sec_out = sec_reg;
    assign running = running_reg;
    assign alarm   = alarm_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer. Works with or without TICK_SYNC_EN;
// the expected tick-to-decrement latency follows the macro.
module tb_countdown_timer;

`ifdef TICK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst;
    logic       tick_in;
    logic       load;
    logic [6:0] min_in;
    logic [5:0] sec_in;
    logic       start;
    logic       pause;
    logic [6:0] min_out;
    logic [5:0] sec_out;
    logic       running;
    logic       alarm;
    logic       done;

    int tests;
    int fails;
    int done_cnt;
    int d0;

    countdown_timer dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .load    (load),
        .min_in  (min_in),
        .sec_in  (sec_in),
        .start   (start),
        .pause   (pause),
        .min_out (min_out),
        .sec_out (sec_out),
        .running (running),
        .alarm   (alarm),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[TB] check %-14s observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_count(input string tag, input int m, input int s);
        chk({tag, ".min"}, 32'(min_out), 32'(m));
        chk({tag, ".sec"}, 32'(sec_out), 32'(s));
    endtask

    task automatic load_val(input int m, input int s);
        @(negedge clk);
        load   = 1'b1;
        min_in = 7'(m);
        sec_in = 6'(s);
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One full 1 Hz period, long enough for either latency option.
    task automatic do_tick();
        @(negedge clk);
        tick_in = 1'b1;
        repeat (4) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0; done_cnt = 0;
        rst = 1'b1; tick_in = 1'b0; load = 1'b0;
        min_in = '0; sec_in = '0; start = 1'b0; pause = 1'b0;

        repeat (3) @(negedge clk);
        chk_count("reset", 0, 0);
        chk("reset.running", 32'(running), 0);
        chk("reset.alarm",   32'(alarm),   0);
        chk("reset.done",    32'(done),    0);
        rst = 1'b0;
        @(negedge clk);

        // 1: 00:03 countdown to alarm
        load_val(0, 3);
        chk_count("t1.load", 0, 3);
        start_pulse();
        chk("t1.running", 32'(running), 1);
        d0 = done_cnt;
        do_tick(); chk_count("t1.tick1", 0, 2);
        do_tick(); chk_count("t1.tick2", 0, 1);
        do_tick(); chk_count("t1.tick3", 0, 0);
        chk("t1.done_once", 32'(done_cnt - d0), 1);
        chk("t1.alarm",     32'(alarm),   1);
        chk("t1.running0",  32'(running), 0);
        do_tick(); chk_count("t1.hold", 0, 0);
        chk("t1.no_redone", 32'(done_cnt - d0), 1);
        start_pulse();
        chk("t1.ack_alarm", 32'(alarm), 0);

        // 2: minute borrow
        load_val(1, 0);
        start_pulse();
        d0 = done_cnt;
        do_tick(); chk_count("t2.borrow", 0, 59);
        for (int i = 0; i < 58; i++) do_tick();
        chk_count("t2.one_left", 0, 1);
        chk("t2.no_done_yet", 32'(done_cnt - d0), 0);
        do_tick(); chk_count("t2.zero", 0, 0);
        chk("t2.done_once", 32'(done_cnt - d0), 1);
        chk("t2.alarm", 32'(alarm), 1);

        // 3: pause / resume, including simultaneous start+pause
        load_val(0, 10);
        chk("t3.load_idle", 32'(alarm), 0);
        start_pulse();
        do_tick(); do_tick();
        chk_count("t3.two_ticks", 0, 8);
        @(negedge clk); pause = 1'b1; start = 1'b1;
        @(negedge clk); pause = 1'b0; start = 1'b0;
        chk("t3.pause_wins", 32'(running), 0);
        do_tick(); do_tick(); do_tick();
        chk_count("t3.frozen", 0, 8);
        @(negedge clk); pause = 1'b1; start = 1'b1;
        @(negedge clk); pause = 1'b0; start = 1'b0;
        chk("t3.start_wins", 32'(running), 1);
        do_tick(); chk_count("t3.resumed", 0, 7);

        // 6a: tick-to-decrement latency, still running at 00:07
        @(negedge clk); tick_in = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            chk("t6.latency", 32'(sec_out), (k < LAT) ? 32'd7 : 32'd6);
        end
        repeat (3) @(negedge clk); tick_in = 1'b0;
        repeat (4) @(negedge clk);

        // 6b: load coincident with tick_edge wins, no decrement
        @(negedge clk); tick_in = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        load = 1'b1; min_in = 7'd0; sec_in = 6'd4;
        @(negedge clk); load = 1'b0;
        chk_count("t6.load_wins", 0, 4);
        chk("t6.idle", 32'(running), 0);
        repeat (4) @(negedge clk); tick_in = 1'b0;
        repeat (4) @(negedge clk);
        chk_count("t6.no_dec", 0, 4);

        // 4: load saturation and start at 00:00
        load_val(120, 63);
        chk_count("t4.saturate", 99, 59);
        load_val(0, 0);
        start_pulse();
        chk("t4.start_zero", 32'(running), 0);

        // 5: asynchronous reset mid-count
        load_val(0, 9);
        start_pulse();
        do_tick(); do_tick(); do_tick(); do_tick();
        chk_count("t5.pre_rst", 0, 5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_count("t5.async", 0, 0);
        chk("t5.running", 32'(running), 0);
        chk("t5.alarm",   32'(alarm),   0);
        chk("t5.done",    32'(done),    0);
        @(negedge clk); rst = 1'b0;
        d0 = done_cnt;
        do_tick(); do_tick();
        chk_count("t5.after", 0, 0);
        chk("t5.no_done", 32'(done_cnt - d0), 0);
        chk("t5.idle",    32'(running), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
